cwe1262_lock_ctrl: RTL and testbench

//   Upstream write controller for a lock-protected register bank.

---
 rtl/cwe1262_lock_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_cwe1262_lock_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cwe1262_lock_ctrl.sv
// -----------------------------------------------------------------------------
// cwe1262_lock_ctrl
//
// Upstream write controller for a lock-protected register bank. One bus write
// is taken at a time over a valid/ready handshake. The controller decodes the
// target, drives a one-hot write-enable pulse plus shared write data into the
// bank, and answers with a response that carries an error flag. A write of 1
// (bit 0) to the lock register at address NUM_REGS sets a sticky lock. Once the
// lock is set, every bank entry is write-protected until rst_n is asserted.
// Blocked writes and writes to undecoded addresses complete with resp_err=1.
//
// Optional feature macro: VIOL_CNT_EN
//   When defined, an 8-bit saturating counter of rejected writes is exposed on
//   viol_cnt. When undefined, the port and its logic are absent.
//
// Parameters
//   DATA_W    width of write data and bank entries
//   NUM_REGS  number of bank entries; the lock register sits at address NUM_REGS
//   ADDR_W    request address width; 2**ADDR_W must exceed NUM_REGS
//
// Ports
//   clk         in   1         single clock, rising edge
//   rst_n       in   1         asynchronous active-low reset
//   req_valid   in   1         write request valid
//   req_ready   out  1         controller can accept a request (IDLE only)
//   req_addr    in   ADDR_W    0..NUM_REGS-1 = bank entry, NUM_REGS = lock reg
//   req_wdata   in   DATA_W    write data
//   resp_valid  out  1         write response valid
//   resp_ready  in   1         response consumer ready
//   resp_err    out  1         response error flag, qualified by resp_valid
//   bank_we     out  NUM_REGS  one-hot per-entry write enable, one-cycle pulse
//   bank_wdata  out  DATA_W    write data to the bank, valid while bank_we != 0
//   lock        out  1         sticky lock, fed to the bank
//   viol_cnt    out  8         rejected-write count (VIOL_CNT_EN builds only)
//
// Timing: a request accepted at the end of cycle T produces the bank_we pulse
// in cycle T+1 (EXEC) and resp_valid from cycle T+2 (RESP). With resp_ready
// held high a new request can be issued every 3 cycles.
// -----------------------------------------------------------------------------
module cwe1262_lock_ctrl #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_err,
    output logic [NUM_REGS-1:0] bank_we,
    output logic [DATA_W-1:0]   bank_wdata,
    output logic                lock
`ifdef VIOL_CNT_EN
    ,
    output logic [7:0]          viol_cnt
`endif
);

    localparam logic [ADDR_W-1:0] LOCK_ADDR = ADDR_W'(NUM_REGS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic                ready_q;    // registered so req_ready is 0 while in reset
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic                lock_q;
    logic                err_q;

    // Decode of the captured request; only meaningful while in EXEC.
    logic                in_exec;
    logic                hit_bank;
    logic                hit_lock;
    logic                wr_ok;      // bank write goes through this cycle
    logic                viol;       // this EXEC cycle ends with err=1
    logic                lock_set;   // lock register written with bit 0 set
    logic                accept;
    logic                resp_done;

    assign in_exec   = (state == EXEC);
    assign hit_bank  = (addr_q < LOCK_ADDR);
    assign hit_lock  = (addr_q == LOCK_ADDR);
    assign accept    = (state == IDLE) && ready_q && req_valid;
    assign resp_done = (state == RESP) && resp_ready;

    // Lock is only ever checked here; a lock write cannot coincide with a bank
    // write because only one request is in flight at a time.
    assign wr_ok    = in_exec && hit_bank && !lock_q;
    assign viol     = in_exec && ((hit_bank && lock_q) || (!hit_bank && !hit_lock));
    assign lock_set = in_exec && hit_lock && data_q[0];

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: default assigned first so every path drives state_nxt and no
        // latch is inferred.
        state_nxt = state;
        unique case (state)
            IDLE: if (accept)    state_nxt = EXEC;
            EXEC:                state_nxt = RESP;
            RESP: if (resp_done) state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // One-hot write enable: compare against each entry index so an address at
    // or above NUM_REGS can never light a bit.
    // -------------------------------------------------------------------------
    always_comb begin
        bank_we = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            bank_we[i] = wr_ok && (addr_q == ADDR_W'(i));
        end
    end

    // -------------------------------------------------------------------------
    // State register and control flops
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments for all sequential state so every
            // flop samples the pre-edge values regardless of statement order.
            state   <= IDLE;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt == IDLE);
        end
    end

    // -------------------------------------------------------------------------
    // Request capture. bank_wdata is driven straight from data_q, so these
    // flops are reset to give bank_wdata its defined post-reset value of 0.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: datapath capture registers are reset only because they feed
            // an output with a required reset value; plain data storage elsewhere
            // would not need it.
            addr_q <= '0;
            data_q <= '0;
        end else if (accept) begin
            addr_q <= req_addr;
            data_q <= req_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Sticky lock: set-only, cleared solely by rst_n.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= 1'b0;
        end else if (lock_set) begin
            lock_q <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Response error flag: resolved at the end of EXEC and held unchanged for
    // the whole RESP stall; dropped on the response handshake.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (in_exec) begin
            err_q <= viol;
        end else if (resp_done) begin
            err_q <= 1'b0;
        end
    end

`ifdef VIOL_CNT_EN
    // -------------------------------------------------------------------------
    // Rejected-write counter, saturating at 255.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            viol_cnt <= 8'd0;
        end else if (viol && (viol_cnt != 8'hFF)) begin
            viol_cnt <= viol_cnt + 8'd1;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign req_ready  = ready_q;
    assign resp_valid = (state == RESP);
    assign resp_err   = err_q;
    assign bank_wdata = data_q;
    assign lock       = lock_q;

endmodule

// File: tb/tb_cwe1262_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cwe1262_lock_ctrl
//
// Directed bench for cwe1262_lock_ctrl with hand-computed expectations.
// Inputs are driven and outputs sampled on the falling clock edge; the DUT
// acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_cwe1262_lock_ctrl;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 4;
    localparam int ADDR_W   = 3;

    logic                clk;
    logic                rst_n;
    logic                req_valid;
    logic                req_ready;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic                resp_valid;
    logic                resp_ready;
    logic                resp_err;
    logic [NUM_REGS-1:0] bank_we;
    logic [DATA_W-1:0]   bank_wdata;
    logic                lock;
`ifdef VIOL_CNT_EN
    logic [7:0]          viol_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    cwe1262_lock_ctrl #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_err   (resp_err),
        .bank_we    (bank_we),
        .bank_wdata (bank_wdata),
        .lock       (lock)
`ifdef VIOL_CNT_EN
        ,
        .viol_cnt   (viol_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Wait on falling edges until req_ready is seen, within a cycle budget.
    task automatic wait_ready(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) check({tag, "_ready_timeout"}, 64'(req_ready), 64'd1);
    endtask

    // One full transaction with resp_ready held high. Called on a falling edge.
    task automatic write_txn(input string tag, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d, input logic [NUM_REGS-1:0] exp_we,
                             input logic exp_err, input logic exp_lock);
        wait_ready(tag);
        req_valid = 1'b1;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);                       // EXEC
        req_valid = 1'b0;
        check({tag, "_exec_we"}, 64'(bank_we), 64'(exp_we));
        if (exp_we != '0) check({tag, "_exec_wdata"}, 64'(bank_wdata), 64'(d));
        check({tag, "_exec_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_exec_rvalid"}, 64'(resp_valid), 64'd0);
        @(negedge clk);                       // RESP
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'd1);
        check({tag, "_resp_err"}, 64'(resp_err), 64'(exp_err));
        check({tag, "_resp_we"}, 64'(bank_we), 64'd0);
        check({tag, "_lock"}, 64'(lock), 64'(exp_lock));
        @(negedge clk);                       // back in IDLE
        check({tag, "_idle_rvalid"}, 64'(resp_valid), 64'd0);
        check({tag, "_idle_ready"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("rst_req_ready",  64'(req_ready),  64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_err",   64'(resp_err),   64'd0);
        check("rst_bank_we",    64'(bank_we),    64'd0);
        check("rst_bank_wdata", 64'(bank_wdata), 64'd0);
        check("rst_lock",       64'(lock),       64'd0);
`ifdef VIOL_CNT_EN
        check("rst_viol_cnt",   64'(viol_cnt),   64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(req_ready), 64'd1);

        // ---------------- T1: plain write ----------------
        write_txn("t1_w2", 3'd2, 32'hA5A5_0001, 4'b0100, 1'b0, 1'b0);
        write_txn("t1_w0", 3'd0, 32'h0000_1234, 4'b0001, 1'b0, 1'b0);
        write_txn("t1_w3", 3'd3, 32'hFFFF_FFFF, 4'b1000, 1'b0, 1'b0);

        // ---------------- T2: lock, then blocked write ----------------
        write_txn("t2_lock",   3'd4, 32'h0000_0001, 4'b0000, 1'b0, 1'b1);
        write_txn("t2_blk0",   3'd0, 32'hDEAD_BEEF, 4'b0000, 1'b1, 1'b1);

        // ---------------- T3: lock clear attempt, bad address ----------------
        write_txn("t3_clr",    3'd4, 32'h0000_0000, 4'b0000, 1'b0, 1'b1);
        write_txn("t3_relock", 3'd4, 32'h0000_0001, 4'b0000, 1'b0, 1'b1);
        write_txn("t3_bad5",   3'd5, 32'h1111_2222, 4'b0000, 1'b1, 1'b1);
        write_txn("t3_bad7",   3'd7, 32'h3333_4444, 4'b0000, 1'b1, 1'b1);

        // ---------------- T4: stalled response ----------------
        resp_ready = 1'b0;
        wait_ready("t4");
        req_valid = 1'b1;
        req_addr  = 3'd6;                     // undecoded: err=1 expected
        req_wdata = 32'h0;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_stall_rvalid", 64'(resp_valid), 64'd1);
            check("t4_stall_err",    64'(resp_err),   64'd1);
            check("t4_stall_ready",  64'(req_ready),  64'd0);
            check("t4_stall_we",     64'(bank_we),    64'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("t4_release_ready",  64'(req_ready),  64'd1);
        check("t4_release_rvalid", 64'(resp_valid), 64'd0);

        // ---------------- T5: reset during EXEC ----------------
        check("t5_pre_lock", 64'(lock), 64'd1);
        wait_ready("t5");
        req_valid = 1'b1;
        req_addr  = 3'd1;
        req_wdata = 32'hCAFE_0001;
        @(posedge clk);                       // accepted, now in EXEC
        #2;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        #1;
        check("t5_rst_we",     64'(bank_we),    64'd0);
        check("t5_rst_lock",   64'(lock),       64'd0);
        check("t5_rst_rvalid", 64'(resp_valid), 64'd0);
        check("t5_rst_ready",  64'(req_ready),  64'd0);
        @(negedge clk);
        check("t5_rst_we2",    64'(bank_we),    64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_after_rvalid", 64'(resp_valid), 64'd0);
        write_txn("t5_w1", 3'd1, 32'hCAFE_0002, 4'b0010, 1'b0, 1'b0);

`ifdef VIOL_CNT_EN
        // ---------------- T6: counter saturation ----------------
        begin
            int we_hits = 0;
            write_txn("t6_lock", 3'd4, 32'h1, 4'b0000, 1'b0, 1'b1);
            check("t6_cnt_start", 64'(viol_cnt), 64'd0);
            for (int i = 0; i < 300; i++) begin
                wait_ready("t6");
                req_valid = 1'b1;
                req_addr  = 3'd3;
                req_wdata = 32'(i);
                @(negedge clk);
                req_valid = 1'b0;
                if (bank_we != '0) we_hits++;
                @(negedge clk);
                if (i == 0) check("t6_first_err", 64'(resp_err), 64'd1);
                if (i == 0) check("t6_cnt_one",   64'(viol_cnt), 64'd1);
                @(negedge clk);
            end
            check("t6_cnt_sat", 64'(viol_cnt), 64'd255);
            check("t6_we_hits", 64'(we_hits),  64'd0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
